// File: rtl/sr_controller_v2.sv
// Multi-cycle control FSM for the simple RISC CPU: fetch, PC update, decode, execute.
// Optional macro BRANCH_EN compiles in B/BL/BX/BLX; without it those opcodes are NOPs.
//
// state    | meaning
// RESET    | clear PC
// IF1      | RAM address = PC, wait RAM_LAT cycles
// IF2      | load IR
// UPD_PC   | PC <= PC+1
// DECODE   | dispatch on {opcode, ALU_op}
// WR_IMM   | Rn <= sximm8
// GET_A    | A <= Rn
// GET_B    | B <= Rm
// ALU      | C <= A op B
// ALU_MV   | C <= 0 op B (MOV/MVN)
// WR       | Rd <= C
// ALU_S    | status <= flags (CMP)
// ADDR     | C <= A + sximm5
// LD_ADDR  | address register <= C
// MEM_RD   | RAM address = addr reg, wait RAM_LAT cycles
// WR_MEM   | Rd <= mdata
// GET_D    | B <= Rd
// PASS     | C <= 0 + B
// MEM_WR   | RAM write strobe
// HALT     | stopped until rst
// BR       | PC <= PC+1+sximm8
// LINK     | R7 <= PC
// BRX      | PC <= C
module sr_controller_v2 #(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [1:0] shift_op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       ram_w_en,
  output logic       sel_addr,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_addr,
  output logic       load_ir,
  output logic [1:0] pc_sel,
  output logic       waiting,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_ALU, S_ALU_MV, S_WR, S_ALU_S, S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM,
    S_GET_D, S_PASS, S_MEM_WR, S_HALT, S_BR, S_LINK, S_BRX
  } state_t;

  localparam logic [1:0] LAT_RELOAD = 2'(RAM_LAT - 1);

  state_t     state, state_nx;
  logic [1:0] lat_cnt;
  logic       lat_done, lat_load;
  logic [4:0] instr;
  logic       br_taken;
  logic       unused_ok;

  assign instr     = {opcode, ALU_op};
  assign lat_done  = (lat_cnt == 2'd0);
  assign unused_ok = ^{shift_op, cond, Z, N, V};

  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = !Z;
      3'b011:  br_taken = N ^ V;
      3'b100:  br_taken = (N ^ V) | Z;
      default: br_taken = 1'b0;
    endcase
  end

  // Reload only on entry so a dwell state always starts with a fresh count.
  assign lat_load = ((state_nx == S_IF1) && (state != S_IF1)) ||
                    ((state_nx == S_MEM_RD) && (state != S_MEM_RD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      lat_cnt <= 2'd0;
    end else begin
      state <= state_nx;
      if (lat_load)
        lat_cnt <= LAT_RELOAD;
      else if (!lat_done)
        lat_cnt <= lat_cnt - 2'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:  state_nx = S_IF1;
      S_IF1:    if (lat_done) state_nx = S_IF2;
      S_IF2:    state_nx = S_UPD_PC;
      S_UPD_PC: state_nx = S_DECODE;
      S_DECODE: begin
        case (instr)
          5'b11010:                   state_nx = S_WR_IMM;
          5'b11000, 5'b10111:         state_nx = S_GET_B;
          5'b10100, 5'b10110, 5'b10101,
          5'b01100, 5'b10000:         state_nx = S_GET_A;
          5'b11100:                   state_nx = S_HALT;
`ifdef BRANCH_EN
          5'b00100:                   state_nx = br_taken ? S_BR : S_IF1;
          5'b01011, 5'b01010:         state_nx = S_LINK;
          5'b01000:                   state_nx = S_GET_D;
`endif
          default:                    state_nx = S_IF1;
        endcase
      end
      S_GET_A:   state_nx = (opcode == 3'b101) ? S_GET_B : S_ADDR;
      S_GET_B: begin
        if (instr == 5'b10101)
          state_nx = S_ALU_S;
        else if (opcode == 3'b110 || instr == 5'b10111)
          state_nx = S_ALU_MV;
        else
          state_nx = S_ALU;
      end
      S_ALU, S_ALU_MV: state_nx = S_WR;
      S_ADDR:    state_nx = S_LD_ADDR;
      S_LD_ADDR: state_nx = (opcode == 3'b011) ? S_MEM_RD : S_GET_D;
      S_MEM_RD:  if (lat_done) state_nx = S_WR_MEM;
      S_GET_D:   state_nx = S_PASS;
      S_PASS:    state_nx = (opcode == 3'b100) ? S_MEM_WR : S_BRX;
      S_LINK:    state_nx = (ALU_op == 2'b11) ? S_BR : S_GET_D;
      S_HALT:    state_nx = S_HALT;
      S_WR, S_ALU_S, S_WR_IMM, S_WR_MEM, S_MEM_WR, S_BR, S_BRX:
                 state_nx = S_IF1;
      default:   state_nx = S_RESET;
    endcase
  end

  always_comb begin
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ram_w_en  = 1'b0;
    sel_addr  = 1'b0;
    load_pc   = 1'b0;
    clear_pc  = 1'b0;
    load_addr = 1'b0;
    load_ir   = 1'b0;
    pc_sel    = 2'b00;
    waiting   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_RESET:   begin load_pc = 1'b1; clear_pc = 1'b1; end
      S_IF1:     sel_addr = 1'b1;
      S_IF2:     begin sel_addr = 1'b1; load_ir = 1'b1; end
      S_UPD_PC:  load_pc = 1'b1;
      S_DECODE:  waiting = 1'b1;
      S_WR_IMM:  begin reg_sel = 2'b10; wb_sel = 2'b10; w_en = 1'b1; end
      S_GET_A:   begin reg_sel = 2'b10; en_A = 1'b1; end
      S_GET_B:   en_B = 1'b1;
      S_ALU:     en_C = 1'b1;
      S_ALU_MV:  begin en_C = 1'b1; sel_A = 1'b1; end
      S_WR:      begin reg_sel = 2'b01; w_en = 1'b1; end
      S_ALU_S:   en_status = 1'b1;
      S_ADDR:    begin sel_B = 1'b1; en_C = 1'b1; end
      S_LD_ADDR: load_addr = 1'b1;
      S_WR_MEM:  begin reg_sel = 2'b01; wb_sel = 2'b11; w_en = 1'b1; end
      S_GET_D:   begin reg_sel = 2'b01; en_B = 1'b1; end
      S_PASS:    begin sel_A = 1'b1; en_C = 1'b1; end
      S_MEM_WR:  ram_w_en = 1'b1;
      S_HALT:    halted = 1'b1;
`ifdef BRANCH_EN
      S_BR:      begin load_pc = 1'b1; pc_sel = 2'b01; end
      S_LINK:    begin reg_sel = 2'b11; wb_sel = 2'b01; w_en = 1'b1; end
      S_BRX:     begin load_pc = 1'b1; pc_sel = 2'b10; end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sr_controller_v2.sv
// Bench for sr_controller_v2: two instances (RAM_LAT 1 and 3) checked cycle by cycle
// against per-instruction step lists expanded from the instruction rules.
module tb_sr_controller_v2;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, ram_w_en;
    logic       sel_addr, load_pc, clear_pc, load_addr, load_ir;
    logic [1:0] pc_sel;
    logic       waiting, halted;
  } outv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] opcode [2];
  logic [1:0] alu_op [2];
  logic [1:0] shift_op [2];
  logic [2:0] cond [2];
  logic       z_f [2];
  logic       n_f [2];
  logic       v_f [2];
  outv_t      obs [2];

  int nchk = 0;
  int npass = 0;
  string seq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [1:0] reg_sel, wb_sel, pc_sel;
    logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, ram_w_en;
    logic sel_addr, load_pc, clear_pc, load_addr, load_ir, waiting, halted;

    sr_controller_v2 #(.RAM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode[g]), .ALU_op(alu_op[g]),
      .shift_op(shift_op[g]), .cond(cond[g]), .Z(z_f[g]), .N(n_f[g]), .V(v_f[g]),
      .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
      .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
      .ram_w_en(ram_w_en), .sel_addr(sel_addr), .load_pc(load_pc),
      .clear_pc(clear_pc), .load_addr(load_addr), .load_ir(load_ir),
      .pc_sel(pc_sel), .waiting(waiting), .halted(halted)
    );

    assign obs[g] = {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A,
                     sel_B, ram_w_en, sel_addr, load_pc, clear_pc, load_addr,
                     load_ir, pc_sel, waiting, halted};
  end

  function automatic outv_t exp_of(string s);
    outv_t o = '0;
    if (s == "RESET")        begin o.load_pc = 1; o.clear_pc = 1; end
    else if (s == "IF1")     o.sel_addr = 1;
    else if (s == "IF2")     begin o.sel_addr = 1; o.load_ir = 1; end
    else if (s == "UPD_PC")  o.load_pc = 1;
    else if (s == "DECODE")  o.waiting = 1;
    else if (s == "WR_IMM")  begin o.reg_sel = 2'b10; o.wb_sel = 2'b10; o.w_en = 1; end
    else if (s == "GET_A")   begin o.reg_sel = 2'b10; o.en_A = 1; end
    else if (s == "GET_B")   o.en_B = 1;
    else if (s == "ALU")     o.en_C = 1;
    else if (s == "ALU_MV")  begin o.en_C = 1; o.sel_A = 1; end
    else if (s == "WR")      begin o.reg_sel = 2'b01; o.w_en = 1; end
    else if (s == "ALU_S")   o.en_status = 1;
    else if (s == "ADDR")    begin o.sel_B = 1; o.en_C = 1; end
    else if (s == "LD_ADDR") o.load_addr = 1;
    else if (s == "MEM_RD")  o.sel_addr = 0;
    else if (s == "WR_MEM")  begin o.reg_sel = 2'b01; o.wb_sel = 2'b11; o.w_en = 1; end
    else if (s == "GET_D")   begin o.reg_sel = 2'b01; o.en_B = 1; end
    else if (s == "PASS")    begin o.sel_A = 1; o.en_C = 1; end
    else if (s == "MEM_WR")  o.ram_w_en = 1;
    else if (s == "HALT")    o.halted = 1;
    else if (s == "BR")      begin o.load_pc = 1; o.pc_sel = 2'b01; end
    else if (s == "LINK")    begin o.reg_sel = 2'b11; o.wb_sel = 2'b01; o.w_en = 1; end
    else if (s == "BRX")     begin o.load_pc = 1; o.pc_sel = 2'b10; end
    return o;
  endfunction

  function automatic logic taken(logic [2:0] c, logic z, logic n, logic v);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle step list for one instruction, starting at IF1 entry.
  function automatic void build(int lat, logic [2:0] op, logic [1:0] alu,
                                logic [2:0] c, logic z, logic n, logic v);
    logic [4:0] k = {op, alu};
    seq.delete();
    for (int i = 0; i < lat; i++) seq.push_back("IF1");
    seq.push_back("IF2"); seq.push_back("UPD_PC"); seq.push_back("DECODE");
    if (k == 5'b11010) seq.push_back("WR_IMM");
    else if (k == 5'b11000 || k == 5'b10111) begin
      seq.push_back("GET_B"); seq.push_back("ALU_MV"); seq.push_back("WR");
    end else if (k == 5'b10100 || k == 5'b10110) begin
      seq.push_back("GET_A"); seq.push_back("GET_B"); seq.push_back("ALU"); seq.push_back("WR");
    end else if (k == 5'b10101) begin
      seq.push_back("GET_A"); seq.push_back("GET_B"); seq.push_back("ALU_S");
    end else if (k == 5'b01100) begin
      seq.push_back("GET_A"); seq.push_back("ADDR"); seq.push_back("LD_ADDR");
      for (int i = 0; i < lat; i++) seq.push_back("MEM_RD");
      seq.push_back("WR_MEM");
    end else if (k == 5'b10000) begin
      seq.push_back("GET_A"); seq.push_back("ADDR"); seq.push_back("LD_ADDR");
      seq.push_back("GET_D"); seq.push_back("PASS"); seq.push_back("MEM_WR");
    end
`ifdef BRANCH_EN
    else if (k == 5'b00100) begin
      if (taken(c, z, n, v)) seq.push_back("BR");
    end else if (k == 5'b01011) begin
      seq.push_back("LINK"); seq.push_back("BR");
    end else if (k == 5'b01000 || k == 5'b01010) begin
      if (k == 5'b01010) seq.push_back("LINK");
      seq.push_back("GET_D"); seq.push_back("PASS"); seq.push_back("BRX");
    end
`endif
  endfunction

  task automatic check(input int d, input string tag);
    nchk++;
    assert (obs[d] === exp_of(tag)) npass++;
    else $error("FAIL dut%0d %s observed=%h expected=%h", d, tag, obs[d], exp_of(tag));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check(0, "RESET");
    check(1, "RESET");
    @(posedge clk); #1;
  endtask

  // Called at IF1 entry of dut d; returns at the next IF1 entry (or after a reset).
  task automatic run(input int d, input logic [2:0] op, input logic [1:0] alu,
                     input logic [2:0] c, input logic z, input logic n, input logic v,
                     input string abort_at, input int halt_cycles);
    bit is_halt;
    opcode[d] = op; alu_op[d] = alu; cond[d] = c;
    z_f[d] = z; n_f[d] = n; v_f[d] = v;
    shift_op[d] = 2'($urandom_range(0, 3));
    build(d == 0 ? 1 : 3, op, alu, c, z, n, v);
    is_halt = ({op, alu} == 5'b11100);
    if (is_halt) for (int i = 0; i < halt_cycles; i++) seq.push_back("HALT");
    for (int i = 0; i < seq.size(); i++) begin
      check(d, seq[i]);
      if (seq[i] == abort_at || (is_halt && i == seq.size() - 1)) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0] r_op, r_c;
    logic [1:0] r_alu;
    for (int d = 0; d < 2; d++) begin
      opcode[d] = 3'b000; alu_op[d] = 2'b00; shift_op[d] = 2'b00; cond[d] = 3'b000;
      z_f[d] = 1'b0; n_f[d] = 1'b0; v_f[d] = 1'b0;
    end
    do_reset();

    run(0, 3'b110, 2'b10, 3'd0, 0, 0, 0, "", 0);   // MOV imm
    run(0, 3'b101, 2'b00, 3'd0, 0, 0, 0, "", 0);   // ADD
    run(0, 3'b101, 2'b01, 3'd0, 1, 0, 0, "", 0);   // CMP
    run(0, 3'b110, 2'b00, 3'd0, 0, 0, 0, "", 0);   // MOV
    run(0, 3'b101, 2'b11, 3'd0, 0, 0, 0, "", 0);   // MVN
    run(0, 3'b101, 2'b10, 3'd0, 0, 0, 0, "", 0);   // AND
    run(0, 3'b011, 2'b00, 3'd0, 0, 0, 0, "", 0);   // LDR
    run(0, 3'b100, 2'b00, 3'd0, 0, 0, 0, "", 0);   // STR
    run(0, 3'b000, 2'b11, 3'd0, 0, 0, 0, "", 0);   // NOP
    run(0, 3'b001, 2'b00, 3'd1, 1, 0, 0, "", 0);   // BEQ, Z=1
    run(0, 3'b001, 2'b00, 3'd2, 1, 0, 0, "", 0);   // BNE, Z=1
    run(0, 3'b010, 2'b11, 3'd0, 0, 0, 0, "", 0);   // BL
    run(0, 3'b010, 2'b00, 3'd0, 0, 0, 0, "", 0);   // BX
    run(0, 3'b010, 2'b10, 3'd0, 0, 0, 0, "", 0);   // BLX
    run(0, 3'b100, 2'b00, 3'd0, 0, 0, 0, "MEM_WR", 0);

    do_reset();
    run(1, 3'b011, 2'b00, 3'd0, 0, 0, 0, "", 0);   // LDR, 13 cycles
    run(1, 3'b100, 2'b00, 3'd0, 0, 0, 0, "", 0);
    run(1, 3'b110, 2'b10, 3'd0, 0, 0, 0, "", 0);

    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        r_op  = 3'($urandom_range(0, 7));
        r_alu = 2'($urandom_range(0, 3));
        r_c   = 3'($urandom_range(0, 7));
        if ({r_op, r_alu} == 5'b11100) r_alu = 2'b01;
        run(d, r_op, r_alu, r_c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "", 0);
      end
    end

    do_reset();
    run(0, 3'b111, 2'b00, 3'd0, 0, 0, 0, "", 20);  // HALT then reset
    run(0, 3'b110, 2'b10, 3'd0, 0, 0, 0, "", 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
